// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 1 may hold a bounded burst lock. All memory strobes and port outputs are registered.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    input  logic          lock1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);
    localparam logic [7:0] LockMax = 8'(MAX_LOCK);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;  // port owning the current or just-completed access
    logic          rr_q, rr_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] din_q, din_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic in_done, lock_full, lock_go, elig0, elig1, sel;

    // A locked port-1 burst keeps its held request live across DONE until the
    // lock is exhausted and port 0 is waiting.
    always_comb begin
        in_done   = (state_q == StDone);
        lock_full = (lock_cnt_q >= LockMax);
        lock_go   = lock1 && (lock_cnt_q != 8'd0) && !(lock_full && req0);
        elig0     = req0 && !(in_done && !gnt_q);
        elig1     = req1 && (!(in_done && gnt_q) || lock_go);
        if (elig0 && elig1) begin
            if (lock1 && !lock_full) begin
                sel = 1'b1;
            end else if (lock_full) begin
                sel = 1'b0;
            end else begin
                sel = rr_q;
            end
        end else begin
            sel = elig1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            StAccess: begin
                state_d = StDone;
                if (gnt_q) begin
                    done1_d = 1'b1;
                    if (!we_q) rdata1_d = mem_dout;
                end else begin
                    done0_d = 1'b1;
                    if (!we_q) rdata0_d = mem_dout;
                end
            end
            default: begin
                if (elig0 || elig1) begin
                    state_d = StAccess;
                    gnt_d   = sel;
                    addr_d  = sel ? addr1 : addr0;
                    we_d    = sel ? we1 : we0;
                    din_d   = sel ? wdata1 : wdata0;
                    if (sel && lock1) begin
                        rr_d = 1'b1;
                        if (!lock_full) lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        rr_d       = !sel;
                        lock_cnt_d = 8'd0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            rr_q       <= 1'b0;
            lock_cnt_q <= 8'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            din_q      <= din_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_we   = we_q;
    assign mem_din  = din_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized two-port traffic
// checked against a completion-ordered memory model.
module tb_dmem_port_arbiter;
    localparam int unsigned MaxLock = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       done0, done1, mem_we, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         mem_init = 1'b1;
    int         checks = 0, passed = 0;
    int         we_cycles = 0, rule_viol = 0;
    logic       prev_we = 1'b0;
    int         order[$];

    dmem_port_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MaxLock)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
        .lock1(lock1), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Strobe rules: no back-to-back writes, writes only while busy, one done at a time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) we_cycles <= we_cycles + 1;
            if ((mem_we && (prev_we || !busy)) || (done0 && done1)) rule_viol <= rule_viol + 1;
        end
        prev_we <= mem_we;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Two requesters issuing n0/n1 transactions; results checked in completion order.
    task automatic run_traffic(input int n0, input int n1, input int gap_max, input bit lk,
                               input int wait_lim);
        int         left [2];
        bit         pend [2];
        int         gap  [2];
        int         age  [2];
        bit         w    [2];
        logic [7:0] a    [2];
        logic [7:0] d    [2];
        logic       dn, rd;
        left[0] = n0; left[1] = n1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; gap[p] = 0; age[p] = 0; w[p] = 1'b0; a[p] = '0; d[p] = '0;
        end
        order.delete();
        lock1 = lk;
        for (int cyc = 0; cyc < 3000 && (left[0] + left[1] > 0 || pend[0] || pend[1]); cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) age[p]++;
                dn = (p == 0) ? done0 : done1;
                rd = (p == 0) ? rdata0 : rdata1;
                if (dn) begin
                    checks++;
                    if (!pend[p]) $display("FAIL spurious_done%0d: got done=1 want 0", p);
                    else passed++;
                end
                if (dn && pend[p]) begin
                    order.push_back(p);
                    if (!w[p]) begin
                        checks++;
                        if (((p == 0) ? rdata0 : rdata1) !== ref_mem[a[p]])
                            $display("FAIL rdata%0d @%h: got %h want %h", p, a[p],
                                     (p == 0) ? rdata0 : rdata1, ref_mem[a[p]]);
                        else passed++;
                    end else begin
                        ref_mem[a[p]] = d[p];
                    end
                    if (wait_lim > 0) begin
                        checks++;
                        if (age[p] > wait_lim)
                            $display("FAIL wait%0d: got %0d cycles want <= %0d", p, age[p], wait_lim);
                        else passed++;
                    end
                    pend[p] = 1'b0;
                    gap[p]  = int'($urandom_range(gap_max, 0));
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && left[p] > 0) begin
                    if (gap[p] > 0) begin
                        gap[p]--;
                    end else begin
                        pend[p] = 1'b1; left[p]--; age[p] = 0;
                        w[p] = 1'($urandom_range(1, 0));
                        a[p] = 8'h80 | 8'($urandom_range(7, 0));
                        d[p] = 8'($urandom);
                    end
                end
            end
            req0 = pend[0]; we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
            req1 = pend[1]; we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
        end
        checks++;
        if (pend[0] || pend[1] || left[0] + left[1] > 0)
            $display("FAIL traffic_timeout: got %0d outstanding want 0",
                     left[0] + left[1] + int'(pend[0]) + int'(pend[1]));
        else passed++;
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_init = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_addr, mem_din, rdata0, rdata1} !== 32'h0)
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_din, rdata0, rdata1});
        else passed++;
        checks++;
        if ({mem_we, done0, done1, busy} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000", {mem_we, done0, done1, busy});
        else passed++;
        mem_init = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, busy} !== 2'b00) $display("FAIL idle_hold: got %b want 00", {mem_we, busy});
            else passed++;
        end
    endtask

    task automatic test_write_read();
        int w0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 8'h5A; w0 = we_cycles;
        @(negedge clk);
        checks++;
        if ({busy, mem_we, done0, mem_addr, mem_din} !== {3'b110, 8'h33, 8'h5A})
            $display("FAIL wr_access: got %h want %h", {busy, mem_we, done0, mem_addr, mem_din},
                     {3'b110, 8'h33, 8'h5A});
        else passed++;
        addr0 = 8'hFF; wdata0 = 8'h00;
        @(negedge clk);
        checks++;
        if ({done0, mem_we, mem_addr, mem_din} !== {2'b10, 8'h33, 8'h5A})
            $display("FAIL wr_done: got %h want %h", {done0, mem_we, mem_addr, mem_din},
                     {2'b10, 8'h33, 8'h5A});
        else passed++;
        req0 = 1'b0; ref_mem[8'h33] = 8'h5A;
        @(negedge clk);
        checks++;
        if ({done0, busy} !== 2'b00) $display("FAIL wr_end: got %b want 00", {done0, busy});
        else passed++;
        checks++;
        if (we_cycles - w0 !== 1) $display("FAIL we_width: got %0d want 1", we_cycles - w0);
        else passed++;
        checks++;
        if (mem[8'h33] !== 8'h5A) $display("FAIL mem_33: got %h want 5a", mem[8'h33]);
        else passed++;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33;
        @(negedge clk);
        checks++;
        if ({mem_we, done0, mem_addr} !== {2'b00, 8'h33})
            $display("FAIL rd_access: got %h want %h", {mem_we, done0, mem_addr}, {2'b00, 8'h33});
        else passed++;
        @(negedge clk);
        checks++;
        if ({done0, rdata0} !== {1'b1, 8'h5A})
            $display("FAIL rd_done: got %h want %h", {done0, rdata0}, {1'b1, 8'h5A});
        else passed++;
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({done0, rdata0} !== {1'b0, 8'h5A})
            $display("FAIL rd_hold: got %h want %h", {done0, rdata0}, {1'b0, 8'h5A});
        else passed++;
    endtask

    task automatic test_contention();
        int c0, c1;
        c0 = -1; c1 = -1;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'hAB;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (done0 && c0 < 0) begin c0 = cyc; req0 = 1'b0; end
            if (done1 && c1 < 0) begin c1 = cyc; req1 = 1'b0; end
        end
        ref_mem[8'h20] = 8'hAB;
        checks++;
        if (c0 != 2) $display("FAIL cont_done0: got cycle %0d want 2", c0);
        else passed++;
        checks++;
        if (c1 != 4) $display("FAIL cont_done1: got cycle %0d want 4", c1);
        else passed++;
        checks++;
        if (rdata0 !== ref_mem[8'h10]) $display("FAIL cont_rdata0: got %h want %h", rdata0,
                                                ref_mem[8'h10]);
        else passed++;
        checks++;
        if (mem[8'h20] !== 8'hAB) $display("FAIL cont_mem20: got %h want ab", mem[8'h20]);
        else passed++;
    endtask

    task automatic test_fairness();
        do_reset();
        run_traffic(4, 4, 0, 1'b0, 6);
        checks++;
        if (order.size() != 8) $display("FAIL fair_count: got %0d want 8", order.size());
        else passed++;
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != i % 2) $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i],
                                            i % 2);
            else passed++;
        end
    endtask

    task automatic test_lock();
        int exp_q[$];
        int cnt, l0, l1;
        cnt = 0; l0 = 1; l1 = 6;
        while (l0 + l1 > 0) begin
            if (l0 > 0 && (l1 == 0 || cnt >= int'(MaxLock))) begin
                exp_q.push_back(0); l0--; cnt = 0;
            end else begin
                exp_q.push_back(1); l1--; cnt++;
            end
        end
        do_reset();
        run_traffic(1, 6, 0, 1'b1, 0);
        checks++;
        if (order.size() != exp_q.size())
            $display("FAIL lock_count: got %0d want %0d", order.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < order.size() && i < exp_q.size(); i++) begin
            checks++;
            if (order[i] != exp_q[i]) $display("FAIL lock_order[%0d]: got %0d want %0d", i,
                                               order[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h77; lock1 = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) $display("FAIL mid_access: got we=%b want 1", mem_we);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, done1} !== 3'b000)
            $display("FAIL mid_async: got %b want 000", {mem_we, busy, done1});
        else passed++;
        req1 = 1'b0; lock1 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done1 !== 1'b0) $display("FAIL mid_nodone: got %b want 0", done1);
            else passed++;
        end
        rst_n = 1'b1;
        checks++;
        if (mem[8'h40] !== ref_mem[8'h40])
            $display("FAIL mid_mem40: got %h want %h", mem[8'h40], ref_mem[8'h40]);
        else passed++;
        @(negedge clk);
        checks++;
        if ({busy, done1} !== 2'b00) $display("FAIL mid_idle: got %b want 00", {busy, done1});
        else passed++;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h41;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h42;
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h41) $display("FAIL mid_rr: got addr %h want 41", mem_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if ({done0, rdata0} !== {1'b1, ref_mem[8'h41]})
            $display("FAIL mid_rd0: got %h want %h", {done0, rdata0}, {1'b1, ref_mem[8'h41]});
        else passed++;
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done1, rdata1} !== {1'b1, ref_mem[8'h42]})
            $display("FAIL mid_rd1: got %h want %h", {done1, rdata1}, {1'b1, ref_mem[8'h42]});
        else passed++;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        run_traffic(30, 30, 3, 1'b0, 6);
        run_traffic(20, 20, 2, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (rule_viol != 0) $display("FAIL strobe_rules: got %0d violations want 0", rule_viol);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        test_reset();
        test_write_read();
        test_contention();
        test_fairness();
        test_lock();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
